core_inst_sequencer: RTL

- Parametrised hardware replacement for the hand-scripted instruction stream that drives `core`.
- Generates the 34-bit `inst` word cycle by cycle for the whole flow:
  - per kij: weight SRAM→IFIFO, PE weight load, settle gap, activation SRAM→L0, execute, OFIFO→PSUM drain;
  - then the accumulation pass, with PSUM read addresses computed on-chip (no address file).
- Sits between the host/start logic and `core.inst`.

---
 rtl/core_ctrl_pkg.sv | 38 +++
 rtl/core_inst_sequencer_acc_addr_gen.sv | 83 ++++++++
 rtl/core_inst_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared phase encoding and instruction-word layout for core_inst_sequencer.
//   phase_e   : FSM state encoding, also exported on the phase port
//   B_*       : bit positions of the 34-bit core instruction word
//   INST_IDLE : both SRAMs disabled (CEN/WEN high), every strobe low
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        W2I     = 4'd1,
        LOAD    = 4'd2,
        GAP     = 4'd3,
        A2L0    = 4'd4,
        EXEC    = 4'd5,
        DRAIN   = 4'd6,
        ACC_CLR = 4'd7,
        ACC_RD  = 4'd8,
        ACC_END = 4'd9,
        DONE    = 4'd10
    } phase_e;

    localparam int B_ACC       = 33;
    localparam int B_CEN_P     = 32;
    localparam int B_WEN_P     = 31;
    localparam int B_AP        = 20;
    localparam int B_CEN_X     = 19;
    localparam int B_WEN_X     = 18;
    localparam int B_AX        = 7;
    localparam int B_OFIFO_RD  = 6;
    localparam int B_IFIFO_WR  = 5;
    localparam int B_IFIFO_RD  = 4;
    localparam int B_L0_RD     = 3;
    localparam int B_L0_WR     = 2;
    localparam int B_EXEC      = 1;
    localparam int B_LOAD      = 0;

    localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

endpackage

// File: rtl/core_inst_sequencer_acc_addr_gen.sv
// acc_addr_gen: PSUM read address for the accumulation pass, built from nested counters.
//   clk, reset   : clock, asynchronous active-low reset
//   advance_tap  : step to the next kernel tap (kj wraps at K into ki; ki wraps at K to 0)
//   advance_out  : step to the next output pixel (ocol wraps at OW into the next row)
//   clear        : synchronous return to output 0, tap 0
//   pmem_addr    : kij*LEN_NIJ + (orow+ki)*IW + ocol + kj for the current counters
module acc_addr_gen #(
    parameter int IW     = 6,
    parameter int K      = 3,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance_tap,
    input  logic              advance_out,
    input  logic              clear,
    output logic [ADDR_W-1:0] pmem_addr
);
    localparam int OW      = IW - K + 1;
    localparam int LEN_NIJ = IW * IW;
    localparam int KW      = $clog2(K + 1);
    localparam int OWW     = $clog2(OW + 1);

    // Offsets kept as running sums: a kj step moves one kij plane plus one column,
    // a ki step moves K kij planes plus one input row.
    logic [KW-1:0]     kj_q, kj_d, ki_q, ki_d;
    logic [OWW-1:0]    ocol_q, ocol_d;
    logic [ADDR_W-1:0] col_off_q, col_off_d, row_off_q, row_off_d, orow_off_q, orow_off_d;

    always_comb begin
        kj_d       = kj_q;
        ki_d       = ki_q;
        ocol_d     = ocol_q;
        col_off_d  = col_off_q;
        row_off_d  = row_off_q;
        orow_off_d = orow_off_q;
        if (clear) begin
            kj_d       = '0;
            ki_d       = '0;
            ocol_d     = '0;
            col_off_d  = '0;
            row_off_d  = '0;
            orow_off_d = '0;
        end else begin
            if (advance_tap) begin
                if (kj_q == KW'(K - 1)) begin
                    kj_d      = '0;
                    col_off_d = '0;
                    ki_d      = (ki_q == KW'(K - 1)) ? '0 : ki_q + 1'b1;
                    row_off_d = (ki_q == KW'(K - 1)) ? '0 : row_off_q + ADDR_W'(K * LEN_NIJ + IW);
                end else begin
                    kj_d      = kj_q + 1'b1;
                    col_off_d = col_off_q + ADDR_W'(LEN_NIJ + 1);
                end
            end
            if (advance_out) begin
                ocol_d     = (ocol_q == OWW'(OW - 1)) ? '0 : ocol_q + 1'b1;
                orow_off_d = (ocol_q == OWW'(OW - 1)) ? orow_off_q + ADDR_W'(IW) : orow_off_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kj_q       <= '0;
            ki_q       <= '0;
            ocol_q     <= '0;
            col_off_q  <= '0;
            row_off_q  <= '0;
            orow_off_q <= '0;
        end else begin
            kj_q       <= kj_d;
            ki_q       <= ki_d;
            ocol_q     <= ocol_d;
            col_off_q  <= col_off_d;
            row_off_q  <= row_off_d;
            orow_off_q <= orow_off_d;
        end
    end

    assign pmem_addr = row_off_q + col_off_q + orow_off_q + ADDR_W'(ocol_q);

endmodule

// File: rtl/core_inst_sequencer.sv
// core_inst_sequencer: generates the cycle-by-cycle 34-bit instruction stream for core.
//   clk, reset   : clock, asynchronous active-low reset
//   start        : pulse, begins a layer run when idle
//   ofifo_valid  : OFIFO has data (only used when STALL_ON_OFIFO_EN is defined)
//   inst         : registered instruction word
//   acc_clr      : clears the SFU accumulator before each output
//   busy, done   : run in progress / one-cycle end-of-run pulse
//   phase        : current state encoding
//   out_strobe   : sfp_out holds output out_idx
// Optional macro STALL_ON_OFIFO_EN: DRAIN only issues a read after a cycle with ofifo_valid high.
// Every output is decoded from the next state and registered, so phase and inst stay aligned.
module core_inst_sequencer
    import core_ctrl_pkg::*;
#(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int IW      = 6,
    parameter int K       = 3,
    parameter int ADDR_W  = 11,
    parameter int W_BASE  = 1024,
    parameter int GAP_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        acc_clr,
    output logic        busy,
    output logic        done,
    output logic [3:0]  phase,
    output logic        out_strobe,
    output logic [$clog2((IW-K+1)*(IW-K+1))-1:0] out_idx
);
    localparam int LEN_NIJ  = IW * IW;
    localparam int LEN_KIJ  = K * K;
    localparam int OW       = IW - K + 1;
    localparam int LEN_ONIJ = OW * OW;
    localparam int OIW      = $clog2(LEN_ONIJ);
    localparam int KIW      = $clog2(LEN_KIJ + 1);
    localparam int TW       = 16;

    phase_e            state_q, state_d;
    logic [TW-1:0]     t_q, t_d, t_last;
    logic [KIW-1:0]    kij_q, kij_d;
    logic [OIW-1:0]    o_q, o_d, out_idx_d;
    logic [33:0]       inst_d;
    logic              adv, rd_next;
    logic [ADDR_W-1:0] pmem_addr;

`ifdef STALL_ON_OFIFO_EN
    // A DRAIN cycle counts only if it was issued as a read, which was decided
    // from ofifo_valid one cycle earlier.
    assign adv     = (state_q != DRAIN) || inst[B_OFIFO_RD];
    assign rd_next = ofifo_valid;
`else
    logic unused_ofifo_valid;
    assign unused_ofifo_valid = ofifo_valid;
    assign adv     = 1'b1;
    assign rd_next = 1'b1;
`endif

    always_comb begin
        t_last = '0;
        case (state_q)
            W2I:     t_last = TW'(COL);
            LOAD:    t_last = TW'(ROW + 2 * COL - 1);
            GAP:     t_last = TW'(GAP_CYC - 1);
            A2L0:    t_last = TW'(LEN_NIJ);
            EXEC:    t_last = TW'(LEN_NIJ + ROW + COL - 1);
            DRAIN:   t_last = TW'(LEN_NIJ - 1);
            ACC_RD:  t_last = TW'(LEN_KIJ);
            default: t_last = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        t_d     = adv ? t_q + 1'b1 : t_q;
        kij_d   = kij_q;
        o_d     = o_q;
        if (state_q == IDLE) begin
            t_d   = '0;
            kij_d = '0;
            o_d   = '0;
            if (start) state_d = W2I;
        end else if (adv && t_q == t_last) begin
            t_d = '0;
            case (state_q)
                W2I:     state_d = LOAD;
                LOAD:    state_d = GAP;
                GAP:     state_d = A2L0;
                A2L0:    state_d = EXEC;
                EXEC:    state_d = DRAIN;
                DRAIN: begin
                    state_d = (kij_q == KIW'(LEN_KIJ - 1)) ? ACC_CLR : W2I;
                    kij_d   = (kij_q == KIW'(LEN_KIJ - 1)) ? kij_q : kij_q + 1'b1;
                end
                ACC_CLR: state_d = ACC_RD;
                ACC_RD:  state_d = ACC_END;
                ACC_END: begin
                    state_d = (o_q == OIW'(LEN_ONIJ - 1)) ? DONE : ACC_CLR;
                    o_d     = o_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        inst_d = INST_IDLE;
        case (state_d)
            W2I: begin
                if (t_d < TW'(COL)) begin
                    inst_d[B_CEN_X]          = 1'b0;
                    inst_d[B_AX +: ADDR_W]   = ADDR_W'(W_BASE) + ADDR_W'(kij_d) * ADDR_W'(COL) + ADDR_W'(t_d);
                end
                inst_d[B_IFIFO_WR] = t_d != '0;
            end
            LOAD: begin
                inst_d[B_IFIFO_RD] = 1'b1;
                inst_d[B_LOAD]     = 1'b1;
            end
            A2L0: begin
                if (t_d < TW'(LEN_NIJ)) begin
                    inst_d[B_CEN_X]        = 1'b0;
                    inst_d[B_AX +: ADDR_W] = ADDR_W'(t_d);
                end
                inst_d[B_L0_WR] = t_d != '0;
            end
            EXEC: begin
                inst_d[B_L0_RD] = 1'b1;
                inst_d[B_EXEC]  = 1'b1;
            end
            DRAIN: begin
                if (rd_next) begin
                    inst_d[B_OFIFO_RD]     = 1'b1;
                    inst_d[B_CEN_P]        = 1'b0;
                    inst_d[B_WEN_P]        = 1'b0;
                    inst_d[B_AP +: ADDR_W] = ADDR_W'(kij_q) * ADDR_W'(LEN_NIJ) + ADDR_W'(t_d);
                end
            end
            ACC_RD: begin
                if (t_d < TW'(LEN_KIJ)) begin
                    inst_d[B_CEN_P]        = 1'b0;
                    inst_d[B_AP +: ADDR_W] = pmem_addr;
                end
                inst_d[B_ACC] = t_d != '0;
            end
            default: inst_d = INST_IDLE;
        endcase
    end

    assign out_idx_d = (state_d == ACC_END) ? o_q : out_idx;

    // Taps advance as each read is issued, so the counters already point at
    // the following tap when the next instruction is decoded.
    acc_addr_gen #(.IW(IW), .K(K), .ADDR_W(ADDR_W)) u_addr (
        .clk         (clk),
        .reset       (reset),
        .advance_tap (state_d == ACC_RD && t_d < TW'(LEN_KIJ)),
        .advance_out (state_d == ACC_END),
        .clear       (state_q == IDLE),
        .pmem_addr   (pmem_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            t_q        <= '0;
            kij_q      <= '0;
            o_q        <= '0;
            inst       <= INST_IDLE;
            acc_clr    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_strobe <= 1'b0;
            out_idx    <= '0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            kij_q      <= kij_d;
            o_q        <= o_d;
            inst       <= inst_d;
            acc_clr    <= state_d == ACC_CLR;
            busy       <= state_d != IDLE && state_d != DONE;
            done       <= state_d == DONE;
            out_strobe <= state_d == ACC_END;
            out_idx    <= out_idx_d;
        end
    end

    assign phase = state_q;

endmodule
